// File: rtl/vx_ag_tcu_uop_arb.sv
// Round-robin issue arbiter for the shared AG-TCU uop expander.
// Plain heads pass through combinationally; macros are popped, held and expanded by the sequencer.
module vx_ag_tcu_uop_arb #(
    parameter int NUM_REQS  = 4,
    parameter int DATA_W    = 128,
    parameter int REQ_SEL_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQS-1:0]        req_valid,
    input  logic [NUM_REQS-1:0]        req_uop,
    input  logic [NUM_REQS*DATA_W-1:0] req_data,
    output logic [NUM_REQS-1:0]        req_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [REQ_SEL_W-1:0]       out_sel,
    input  logic                       out_ready,
    output logic                       seq_start,
    output logic                       seq_next,
    input  logic                       seq_done,
    output logic [DATA_W-1:0]          seq_data_in,
    input  logic [DATA_W-1:0]          seq_data_out,
    output logic                       busy,
    output logic [31:0]                perf_macros,
    output logic [31:0]                perf_uops
);

    // Handshakes: a transfer on the output side happens when out_valid && out_ready.
    // Plain pops are req_ready[sel] = out_ready; macro pops are unconditional in the start cycle.

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [REQ_SEL_W-1:0]  rr_ptr_q;
    logic [REQ_SEL_W-1:0]  owner_q;
    logic [DATA_W-1:0]     hold_q;
    logic [31:0]           perf_macros_q;
    logic [31:0]           perf_uops_q;

    logic                  found;
    logic [REQ_SEL_W-1:0]  sel;
    logic                  macro_pop;
    logic                  plain_hs;
    logic                  uop_hs;

    // First valid requester strictly after rr_ptr, wrapping around.
    always_comb begin
        int idx;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQS; k++) begin
            idx = int'(rr_ptr_q) + 1 + k;
            if (idx >= NUM_REQS) idx = idx - NUM_REQS;
            if (!found && req_valid[REQ_SEL_W'(idx)]) begin
                found = 1'b1;
                sel   = REQ_SEL_W'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_sel   = '0;
        seq_start = 1'b0;
        seq_next  = 1'b0;
        macro_pop = 1'b0;
        plain_hs  = 1'b0;
        uop_hs    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    if (req_uop[sel]) begin
                        seq_start      = 1'b1;
                        req_ready[sel] = 1'b1;
                        macro_pop      = 1'b1;
                        state_d        = ST_EXPAND;
                    end else begin
                        out_valid      = 1'b1;
                        out_data       = req_data[sel*DATA_W +: DATA_W];
                        out_sel        = sel;
                        req_ready[sel] = out_ready;
                        plain_hs       = out_ready;
                    end
                end
            end
            ST_EXPAND: begin
                out_valid = 1'b1;
                out_data  = seq_data_out;
                out_sel   = owner_q;
                seq_next  = out_ready;
                uop_hs    = out_ready;
                if (out_ready && seq_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= REQ_SEL_W'(NUM_REQS - 1);
            owner_q       <= '0;
            hold_q        <= '0;
            perf_macros_q <= '0;
            perf_uops_q   <= '0;
        end else begin
            state_q <= state_d;
            if (macro_pop) begin
                hold_q        <= req_data[sel*DATA_W +: DATA_W];
                owner_q       <= sel;
                rr_ptr_q      <= sel;
                perf_macros_q <= perf_macros_q + 32'd1;
            end else if (plain_hs) begin
                rr_ptr_q <= sel;
            end
            if (uop_hs) perf_uops_q <= perf_uops_q + 32'd1;
        end
    end

    assign seq_data_in = hold_q;
    assign busy        = (state_q == ST_EXPAND);
    assign perf_macros = perf_macros_q;
    assign perf_uops   = perf_uops_q;

endmodule

// File: tb/tb_vx_ag_tcu_uop_arb.sv
// Directed and randomised bench for vx_ag_tcu_uop_arb with a 4-uop sequencer model.
module tb_vx_ag_tcu_uop_arb;
  localparam int N    = 4;
  localparam int W    = 32;
  localparam int UOPS = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_uop, req_ready;
  logic [N*W-1:0] req_data;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_ready;
  logic           seq_start, seq_next, seq_done;
  logic [W-1:0]   seq_data_in, seq_data_out;
  logic           busy;
  logic [31:0]    perf_macros, perf_uops;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] dval[N];

  int m_rr = 3;
  int m_owner = 0;
  bit m_busy = 0;
  int m_macros = 0;
  int m_uops = 0;

  vx_ag_tcu_uop_arb #(.NUM_REQS(N), .DATA_W(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_uop(req_uop), .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready),
    .seq_start(seq_start), .seq_next(seq_next), .seq_done(seq_done),
    .seq_data_in(seq_data_in), .seq_data_out(seq_data_out),
    .busy(busy), .perf_macros(perf_macros), .perf_uops(perf_uops)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // sequencer model: uop k of a macro is macro + k, last uop flagged with seq_done
  logic [1:0] seq_cnt;
  logic       seq_act;
  always @(posedge clk) begin
    if (reset) begin
      seq_act <= 1'b0;
      seq_cnt <= 2'd0;
    end else if (seq_start) begin
      seq_act <= 1'b1;
      seq_cnt <= 2'd0;
    end else if (seq_next && seq_act) begin
      if (seq_cnt == 2'(UOPS - 1)) seq_act <= 1'b0;
      seq_cnt <= seq_cnt + 2'd1;
    end
  end
  assign seq_data_out = seq_act ? (seq_data_in + W'(seq_cnt)) : '0;
  assign seq_done     = seq_act && (seq_cnt == 2'(UOPS - 1));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] u, input logic r);
    req_valid = v;
    req_uop   = u;
    out_ready = r;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = dval[i];
  endtask

  task automatic drive_random();
    req_valid = N'($urandom_range(0, 15));
    req_uop   = N'($urandom_range(0, 15));
    out_ready = ($urandom_range(0, 3) != 0);
    for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom;
  endtask

  // scoreboard for one cycle; model state updates describe the next cycle
  task automatic score_cycle();
    int s;
    bit f;
    int idx;
    check("one_ready", 64'($countones(req_ready) <= 1), 64'd1);
    check("start_busy", 64'(seq_start & busy), 64'd0);
    check("busy", 64'(busy), 64'(m_busy));
    if (m_busy) begin
      check("exp_valid", 64'(out_valid), 64'd1);
      check("exp_sel", 64'(out_sel), 64'(m_owner));
      check("exp_ready", 64'(req_ready), 64'd0);
      check("exp_next", 64'(seq_next), 64'(out_ready));
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("q_underflow", 64'(exp_q.size()), 64'd1);
          m_busy = 0;
        end else begin
          check("uop_data", 64'(out_data), 64'(exp_q.pop_front()));
          m_uops++;
          check("uop_done", 64'(seq_done), 64'(exp_q.size() == 0));
          if (exp_q.size() == 0) m_busy = 0;
        end
      end
    end else begin
      f = 0;
      s = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + 1 + k) % N;
        if (!f && req_valid[idx]) begin
          f = 1;
          s = idx;
        end
      end
      if (!f) begin
        check("idle_valid", 64'(out_valid), 64'd0);
        check("idle_ready", 64'(req_ready), 64'd0);
        check("idle_start", 64'(seq_start), 64'd0);
      end else if (req_uop[s]) begin
        check("mac_start", 64'(seq_start), 64'd1);
        check("mac_valid", 64'(out_valid), 64'd0);
        check("mac_ready", 64'(req_ready), 64'(N'(1) << s));
        for (int k = 0; k < UOPS; k++) exp_q.push_back(req_data[s*W +: W] + W'(k));
        m_rr = s;
        m_owner = s;
        m_busy = 1;
        m_macros++;
      end else begin
        check("pl_valid", 64'(out_valid), 64'd1);
        check("pl_sel", 64'(out_sel), 64'(s));
        check("pl_data", 64'(out_data), 64'(req_data[s*W +: W]));
        check("pl_ready", 64'(req_ready), out_ready ? 64'(N'(1) << s) : 64'd0);
        check("pl_start", 64'(seq_start), 64'd0);
        if (out_ready) m_rr = s;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) dval[i] = W'(32'h1000_0000 * (i + 1) + 32'h100 * i + 32'h10);
    reset = 1'b1;
    drive('0, '0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    // reset state
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_start", 64'(seq_start), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hold", 64'(seq_data_in), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_sel", 64'(out_sel), 64'd0);
    check("rst_pm", 64'(perf_macros), 64'd0);
    check("rst_pu", 64'(perf_uops), 64'd0);

    // round robin over four plain heads: 0,1,2,3,0
    next_cycle();
    drive(4'b1111, 4'b0000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k != 0) next_cycle();
      #2;
      check("rr_sel", 64'(out_sel), 64'(k % N));
      check("rr_ready", 64'(req_ready), 64'(4'b0001 << (k % N)));
      check("rr_data", 64'(out_data), 64'(dval[k % N]));
      check("rr_valid", 64'(out_valid), 64'd1);
    end

    // macro on requester 2 (rr_ptr=0)
    next_cycle();
    drive(4'b0100, 4'b0100, 1'b1);
    #2;
    check("m2_start", 64'(seq_start), 64'd1);
    check("m2_ready", 64'(req_ready), 64'b0100);
    check("m2_valid0", 64'(out_valid), 64'd0);
    for (int k = 0; k < UOPS; k++) begin
      next_cycle();
      drive(4'b0000, 4'b0000, 1'b1);
      #2;
      check("m2_valid", 64'(out_valid), 64'd1);
      check("m2_sel", 64'(out_sel), 64'd2);
      check("m2_data", 64'(out_data), 64'(dval[2] + W'(k)));
      check("m2_busy", 64'(busy), 64'd1);
      check("m2_noready", 64'(req_ready), 64'd0);
      check("m2_nostart", 64'(seq_start), 64'd0);
      check("m2_done", 64'(seq_done), 64'(k == UOPS - 1));
    end
    next_cycle();
    #2;
    check("m2_idle", 64'(busy), 64'd0);
    check("m2_pm", 64'(perf_macros), 64'd1);
    check("m2_pu", 64'(perf_uops), 64'd4);

    // macro on requester 0 with a 3-cycle downstream stall (rr_ptr=2)
    next_cycle();
    drive(4'b0001, 4'b0001, 1'b1);
    #2;
    check("st_start", 64'(seq_start), 64'd1);
    check("st_ready", 64'(req_ready), 64'b0001);
    next_cycle();
    drive(4'b0000, 4'b0000, 1'b1);
    #2;
    check("st_d0", 64'(out_data), 64'(dval[0]));
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      drive(4'b0000, 4'b0000, 1'b0);
      #2;
      check("st_hold", 64'(out_data), 64'(dval[0] + 1));
      check("st_next", 64'(seq_next), 64'd0);
      check("st_valid", 64'(out_valid), 64'd1);
    end
    for (int k = 1; k < UOPS; k++) begin
      next_cycle();
      drive(4'b0000, 4'b0000, 1'b1);
      #2;
      check("st_d", 64'(out_data), 64'(dval[0] + W'(k)));
      check("st_busy", 64'(busy), 64'd1);
    end
    next_cycle();
    #2;
    check("st_idle", 64'(busy), 64'd0);
    check("st_pm", 64'(perf_macros), 64'd2);
    check("st_pu", 64'(perf_uops), 64'd8);

    // macro on 1 and plain on 3 with rr_ptr=0; no preemption
    next_cycle();
    drive(4'b1010, 4'b0010, 1'b1);
    #2;
    check("mx_start", 64'(seq_start), 64'd1);
    check("mx_ready", 64'(req_ready), 64'b0010);
    for (int k = 0; k < UOPS; k++) begin
      next_cycle();
      drive(4'b1010, 4'b0000, 1'b1);
      #2;
      check("mx_sel", 64'(out_sel), 64'd1);
      check("mx_data", 64'(out_data), 64'(dval[1] + W'(k)));
      check("mx_noready", 64'(req_ready), 64'd0);
    end
    next_cycle();
    #2;
    check("mx_sel3", 64'(out_sel), 64'd3);
    check("mx_ready3", 64'(req_ready), 64'b1000);
    check("mx_data3", 64'(out_data), 64'(dval[3]));
    check("mx_pm", 64'(perf_macros), 64'd3);
    check("mx_pu", 64'(perf_uops), 64'd12);
    next_cycle();
    #2;
    check("mx_sel1", 64'(out_sel), 64'd1);
    check("mx_ready1", 64'(req_ready), 64'b0010);

    // reset during the second uop of a macro on requester 2 (rr_ptr=1)
    next_cycle();
    drive(4'b0100, 4'b0100, 1'b1);
    #2;
    check("rs_start", 64'(seq_start), 64'd1);
    next_cycle();
    drive(4'b0000, 4'b0000, 1'b1);
    #2;
    check("rs_d0", 64'(out_data), 64'(dval[2]));
    next_cycle();
    #2;
    check("rs_d1", 64'(out_data), 64'(dval[2] + 1));
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    #2;
    check("rs_busy", 64'(busy), 64'd0);
    check("rs_hold", 64'(seq_data_in), 64'd0);
    check("rs_ready", 64'(req_ready), 64'd0);
    check("rs_valid", 64'(out_valid), 64'd0);
    check("rs_pm", 64'(perf_macros), 64'd0);
    check("rs_pu", 64'(perf_uops), 64'd0);
    drive(4'b1111, 4'b0000, 1'b1);
    #1;
    check("rs_rrptr", 64'(out_sel), 64'd0);
    drive(4'b0000, 4'b0000, 1'b1);

    // randomised stream against the scoreboard
    m_rr = 3;
    for (int c = 0; c < 1000; c++) begin
      next_cycle();
      drive_random();
      #2;
      score_cycle();
    end
    for (int c = 0; c < 10 && m_busy; c++) begin
      next_cycle();
      drive(4'b0000, 4'b0000, 1'b1);
      #2;
      score_cycle();
    end
    check("rnd_q_empty", 64'(exp_q.size()), 64'd0);
    next_cycle();
    #2;
    check("rnd_pm", 64'(perf_macros), 64'(m_macros));
    check("rnd_pu", 64'(perf_uops), 64'(m_uops));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vx_ag_tcu_uop_arb.md
# VX_ag_tcu_uop_arb

Round-robin issue arbiter and sequencing controller for the shared AG-TCU micro-op expander. It selects one instruction per cycle from NUM_REQS per-warp ibuffer heads. Ordinary instructions pass through with zero latency. A TCU macro instruction is popped, held, and expanded through the uop sequencer (start/next/done protocol) into AG_TCU_UOPS back-to-back uops before arbitration resumes. It sits between the per-warp ibuffers and the operand-collector/dispatch input.

## Interface
Parameters:
- NUM_REQS, 4: number of requesters (warps); ≥1.
- DATA_W, 128: packed ibuffer entry width.
- REQ_SEL_W, `UP($clog2(NUM_REQS))`: owner index width (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQS  ibuffer head valid, one per requester.
- req_uop  in  NUM_REQS  head is a TCU macro needing expansion.
- req_data  in  NUM_REQS*DATA_W  head entries; requester i at [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQS  pop strobe; at most one bit set per cycle.
- out_valid  out  1  issued entry valid.
- out_data  out  DATA_W  issued entry.
- out_sel  out  REQ_SEL_W  requester that owns out_data.
- out_ready  in  1  downstream accept.
- seq_start  out  1  one-cycle start pulse to the sequencer.
- seq_next  out  1  advance the sequencer; equals the uop handshake.
- seq_done  in  1  sequencer presenting its last uop.
- seq_data_in  out  DATA_W  held macro driven to the sequencer.
- seq_data_out  in  DATA_W  current uop from the sequencer.
- busy  out  1  expansion in progress (state EXPAND).
- perf_macros  out  32  count of expanded macros; wraps.
- perf_uops  out  32  count of uops issued; wraps.

## Operation
- State machine with two states: IDLE and EXPAND.
- IDLE, selection:
  - sel = first requester with req_valid=1, scanning from rr_ptr+1 upward modulo NUM_REQS.
  - No valid requester: all outputs zero.
- IDLE, sel is a plain instruction (req_uop[sel]=0):
  - out_valid=1, out_data=req_data[sel], out_sel=sel.
  - req_ready[sel]=out_ready.
  - On handshake, rr_ptr<=sel.
- IDLE, sel is a macro (req_uop[sel]=1):
  - out_valid=0, seq_start=1, req_ready[sel]=1. The macro is popped unconditionally.
  - hold<=req_data[sel], owner<=sel, rr_ptr<=sel, perf_macros++.
  - Next state EXPAND.
- EXPAND:
  - out_valid=1, out_data=seq_data_out, out_sel=owner.
  - req_ready=0, seq_data_in=hold.
  - seq_next=out_ready. Each handshake increments perf_uops.
  - Handshake with seq_done=1 returns to IDLE. That uop is the last one.
  - With out_ready=0: outputs stay stable and seq_next=0.
- seq_data_in is driven from hold in every state. Hold is cleared to 0 on reset.
- Reset, including mid-EXPAND:
  - State<=IDLE, rr_ptr<=NUM_REQS-1 (so requester 0 has first priority), owner<=0, hold<=0, perf counters<=0.
  - The in-flight macro is discarded. The sequencer shares the same reset.
- NUM_REQS=1: selection degenerates to req_valid[0]; out_sel=0.

## Timing
- Reset values: all outputs 0.
- Plain instruction: combinational path from req_* to out_*, zero latency. Full throughput of one per cycle.
- Macro: seq_start is in cycle T. The first uop is valid at T+1. With no stalls the last uop handshakes at T+AG_TCU_UOPS, and IDLE resumes at T+AG_TCU_UOPS+1.
- Cost per macro: exactly one bubble cycle (the start cycle).
- seq_start is high only in IDLE cycles with a macro selected. It never asserts while busy=1.
- req_ready never asserts in EXPAND. Requesters see no pop during expansion.
- Valid signals arriving during EXPAND wait; there is no preemption.
- req_valid dropping on a non-selected requester has no effect. Inputs are sampled only at the selection/pop cycle.

## Test plan
Bench uses a sequencer model with AG_TCU_UOPS=4, NUM_REQS=4, out_ready=1 unless stated.
- Reset → all outputs 0. With req_valid=4'b1111 and all plain, grants follow 0,1,2,3,0 on consecutive cycles.
- req_valid=4'b0100, req_uop[2]=1 at T:
  - seq_start=1 and req_ready=4'b0100 at T.
  - out_valid with out_sel=2 at T+1..T+4. seq_done is seen at T+4.
  - IDLE at T+5. perf_macros=1, perf_uops=4.
- During EXPAND, out_ready held 0 for 3 cycles → out_data stable, seq_next=0, uop count still 4, total duration 8 cycles.
- Requesters 1 (macro) and 3 (plain) both valid, rr_ptr=0:
  - Macro on 1 expands first.
  - Requester 3 is granted at T+5, then 1 again if still valid.
- Reset asserted at the 2nd uop of a macro → next cycle IDLE, busy=0, hold=0, no req_ready pulse, rr_ptr=3.
- Mixed stream of 1000 random req_valid/req_uop/out_ready:
  - Scoreboard checks each popped macro yields exactly 4 uops in order.
  - Checks at most one req_ready bit per cycle and no seq_start while busy.
